tcdm_bank_responder: RTL and testbench

// - Slave-side endpoint for one bank port of the TCDM interconnect.
// - Accepts req/add/wen/wdata/be and grants them. Stores words in an internal bank array.
// - Returns rdata at a fixed RespLat cycles after acceptance, as the interconnect requires.
// - Contains a zero-fill INIT FSM, run after reset and on request; banks are not granted while it runs.

---
 rtl/tcdm_bank_responder.sv | 115 +++++++++++
 tb/tb_tcdm_bank_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_responder.sv
// TCDM bank slave: byte-lane word store, fixed-latency load pipe,
// and a zero-fill INIT sequence that blocks grants while it runs.
module tcdm_bank_responder #(
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8,
    parameter int AddrMemWidth = 12,
    parameter int RespLat      = 1,
    parameter bit InitOnReset  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [AddrMemWidth-1:0] add_i,
    input  logic                    wen_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [BeWidth-1:0]      be_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    rvalid_o,
    input  logic                    init_i,
    output logic                    init_done_o
);

    localparam int NumWords = 2 ** AddrMemWidth;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    state_e                  state;
    logic [AddrMemWidth-1:0] init_cnt;
    logic [DataWidth-1:0]    mem [NumWords];
    logic [DataWidth-1:0]    pipe_data [RespLat];
    logic [RespLat-1:0]      pipe_vld;
    logic                    ready;
    logic                    accept;
    logic                    load;
    logic                    store;

    if (RespLat < 1) begin : g_lat_chk
        $fatal(1, "RespLat must be at least 1");
    end

    if (BeWidth * 8 != DataWidth) begin : g_be_chk
        $fatal(1, "BeWidth*8 must equal DataWidth");
    end

    assign ready       = (state == READY);
    assign gnt_o       = req_i & ready;
    assign init_done_o = ready;
    assign accept      = req_i & gnt_o;
    assign load        = accept & ~wen_i;
    assign store       = accept & wen_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= InitOnReset ? INIT : READY;
            init_cnt <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (init_i) begin
                        init_cnt <= '0;
                    end else begin
                        // counter wraps to 0 on the same edge we leave INIT
                        init_cnt <= init_cnt + AddrMemWidth'(1);
                        if (&init_cnt) state <= READY;
                    end
                end
                READY: begin
                    if (init_i) begin
                        state    <= INIT;
                        init_cnt <= '0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (store) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (be_i[b]) mem[add_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // data stages only advance with a valid word, so the last stage holds
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
            for (int i = 0; i < RespLat; i++) pipe_data[i] <= '0;
        end else begin
            pipe_vld[0] <= load;
            if (load) pipe_data[0] <= mem[add_i];
            for (int i = 1; i < RespLat; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign rdata_o  = pipe_data[RespLat-1];
    assign rvalid_o = pipe_vld[RespLat-1];

    a_req_known: assert property (
        @(posedge clk_i) disable iff (rst_i)
        req_i |-> !$isunknown({wen_i, add_i})
    ) else $error("wen_i/add_i unknown while req_i is high");

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: two instances (RespLat 1 and 3) share
// stimulus; a per-cycle model check plus literal directed expectations.
module tb_tcdm_bank_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wen = 1'b0;
    logic        init = 1'b0;
    logic [3:0]  add = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;

    logic        gnt1, rvalid1, done1;
    logic [31:0] rdata1;
    logic        gnt3, rvalid3, done3;
    logic [31:0] rdata3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tcdm_bank_responder #(
        .DataWidth(32), .AddrMemWidth(4), .RespLat(1), .InitOnReset(1'b1)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1),
        .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
        .rdata_o(rdata1), .rvalid_o(rvalid1),
        .init_i(init), .init_done_o(done1)
    );

    tcdm_bank_responder #(
        .DataWidth(32), .AddrMemWidth(4), .RespLat(3), .InitOnReset(1'b1)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3),
        .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
        .rdata_o(rdata3), .rvalid_o(rvalid3),
        .init_i(init), .init_done_o(done3)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: word array, remaining-init counter, schedule of due results.
    int          lat [2] = '{1, 3};
    logic [31:0] mem_m [2][16];
    int          init_left [2];
    bit          sv [2][64];
    logic [31:0] sd [2][64];
    logic [31:0] last [2];
    int          cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                init_left[k] = 16;
                for (int j = 0; j < 64; j++) sv[k][j] = 1'b0;
            end
            cyc = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit rdy;
                rdy = (init_left[k] == 0);
                sv[k][cyc % 64] = 1'b0;
                if (rdy && req) begin
                    if (wen) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) mem_m[k][add][8*b +: 8] = wdata[8*b +: 8];
                    end else begin
                        sv[k][(cyc + lat[k]) % 64] = 1'b1;
                        sd[k][(cyc + lat[k]) % 64] = mem_m[k][add];
                    end
                end
                if (!rdy) begin
                    mem_m[k][16 - init_left[k]] = '0;
                    init_left[k]--;
                end
                if (init) init_left[k] = 16;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ev, rdy;
            if (rst) last[k] = '0;
            rdy = !rst && (init_left[k] == 0);
            ev  = !rst && sv[k][cyc % 64];
            if (ev) last[k] = sd[k][cyc % 64];
            chk($sformatf("gnt%0d", lat[k]), 32'(k ? gnt3 : gnt1), 32'(rdy && req));
            chk($sformatf("done%0d", lat[k]), 32'(k ? done3 : done1), 32'(rdy));
            chk($sformatf("rvalid%0d", lat[k]), 32'(k ? rvalid3 : rvalid1), 32'(ev));
            chk($sformatf("rdata%0d", lat[k]), k ? rdata3 : rdata1, last[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        req = 1'b1; wen = 1'b1; add = a; wdata = d; be = m;
        step();
        req = 1'b0; wen = 1'b0;
    endtask

    task automatic load_chk(input logic [3:0] a, input logic [31:0] exp);
        req = 1'b1; wen = 1'b0; add = a;
        step();
        req = 1'b0;
        chk("lit_rvalid1", 32'(rvalid1), 32'd1);
        chk("lit_rdata1", rdata1, exp);
    endtask

    initial begin
        int n;
        req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_rdata3", rdata3, 32'd0);
        rst = 1'b0;
        // T1: grants blocked for the whole fill
        n = 0;
        while (!gnt1 && n < 40) begin step(); n++; end
        chk("lit_init_cycles", 32'(n), 32'd16);
        chk("lit_gnt3_after_init", 32'(gnt3), 32'd1);
        for (int a = 0; a < 16; a++) load_chk(4'(a), 32'h0);
        // T2: byte lanes
        store(4'd3, 32'hAABBCCDD, 4'b1111);
        store(4'd3, 32'h11223344, 4'b0101);
        load_chk(4'd3, 32'hAA22CC44);
        // T3: streaming on the 3-cycle instance
        for (int a = 0; a < 3; a++) store(4'(a), 32'h100 + 32'(a), 4'hF);
        repeat (4) step();
        req = 1'b1; wen = 1'b0; add = 4'd0; step();
        add = 4'd1; step();
        add = 4'd2; step();
        chk("lit_t3_v0", 32'(rvalid3), 32'd1);
        chk("lit_t3_d0", rdata3, 32'h100);
        wen = 1'b1; add = 4'd9; wdata = 32'h55; be = 4'hF; step();
        chk("lit_t3_d1", rdata3, 32'h101);
        req = 1'b0; wen = 1'b0; step();
        chk("lit_t3_d2", rdata3, 32'h102);
        step();
        chk("lit_t3_store_norv", 32'(rvalid3), 32'd0);
        chk("lit_t3_hold", rdata3, 32'h102);
        // T4: store then load next cycle
        store(4'd5, 32'hDEADBEEF, 4'hF);
        load_chk(4'd5, 32'hDEADBEEF);
        // T5: runtime init together with a load
        req = 1'b1; wen = 1'b0; add = 4'd5; init = 1'b1;
        step();
        init = 1'b0;
        chk("lit_t5_rvalid", 32'(rvalid1), 32'd1);
        chk("lit_t5_rdata", rdata1, 32'hDEADBEEF);
        n = 0;
        while (!gnt1 && n < 40) begin step(); n++; end
        chk("lit_reinit_cycles", 32'(n), 32'd16);
        step();
        req = 1'b0;
        chk("lit_t5_zero", rdata1, 32'h0);
        // T6: reset while a 3-cycle load is in flight
        store(4'd7, 32'h12345678, 4'hF);
        req = 1'b1; wen = 1'b0; add = 4'd7;
        step();
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk("lit_t6_rvalid", 32'(rvalid3), 32'd0);
        chk("lit_t6_rdata", rdata3, 32'h0);
        chk("lit_t6_init", 32'(done3), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lit_t6_no_rvalid", 32'(rvalid3), 32'd0);
        end
        n = 0;
        while (!done3 && n < 40) begin step(); n++; end
        chk("lit_t6_done", 32'(done3), 32'd1);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
